// File: rtl/spi_frame_loader.sv
// spi_frame_loader: parses the byte stream from the SPI receiver into
// framebuffer writes, brightness updates and buffer-swap requests.
// Optional build macro FRAME_CRC_EN adds a trailing XOR checksum byte
// per frame; the swap is issued only when the checksum matches.
module spi_frame_loader #(
  parameter int ADDR_W      = 11,
  parameter int FRAME_BYTES = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              ce,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic [7:0]        brightness,
  output logic              swap,
  output logic              frame_done,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

`ifdef FRAME_CRC_EN
  typedef enum logic [1:0] {IDLE, PIXELS, BRIGHT, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PIXELS, BRIGHT} state_t;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic [7:0]        bright_reg, bright_next;
  logic              we_reg, we_next;
  logic              swap_reg, swap_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              busy_reg;
`ifdef FRAME_CRC_EN
  logic [7:0]        acc_reg, acc_next;
`endif

  // ce crosses from the SPI domain; ce_sync_d remembers the previous
  // synchronised level so a falling edge can be detected.
  logic ce_meta_reg, ce_sync_reg, ce_sync_d_reg;
  logic ce_fall;
  logic accept;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_meta_reg   <= 1'b0;
      ce_sync_reg   <= 1'b0;
      ce_sync_d_reg <= 1'b0;
    end else begin
      ce_meta_reg   <= ce;
      ce_sync_reg   <= ce_meta_reg;
      ce_sync_d_reg <= ce_sync_reg;
    end
  end

  assign ce_fall = ce_sync_d_reg & ~ce_sync_reg;
  // Bytes only count while the chip is selected (synchronised view).
  assign accept  = data_valid & ce_sync_reg;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      bright_reg <= 8'hFF;
      we_reg     <= 1'b0;
      swap_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef FRAME_CRC_EN
      acc_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      bright_reg <= bright_next;
      we_reg     <= we_next;
      swap_reg   <= swap_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      busy_reg   <= (state_next != IDLE);
`ifdef FRAME_CRC_EN
      acc_reg    <= acc_next;
`endif
    end
  end

  // Next-state and next-output decode; an abort outranks any byte.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    bright_next = bright_reg;
    we_next     = 1'b0;
    swap_next   = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
`ifdef FRAME_CRC_EN
    acc_next    = acc_reg;
`endif
    if (ce_fall && state_reg != IDLE) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end else if (accept) begin
      case (state_reg)
        IDLE: begin
          if (data_in == 8'hA0) begin
            cnt_next   = '0;
            state_next = PIXELS;
`ifdef FRAME_CRC_EN
            acc_next   = '0;
`endif
          end else if (data_in == 8'hB0) begin
            state_next = BRIGHT;
          end else if (data_in != 8'h00) begin
            err_next = 1'b1;
          end
        end
        PIXELS: begin
          we_next   = 1'b1;
          addr_next = cnt_reg;
          data_next = data_in;
`ifdef FRAME_CRC_EN
          acc_next  = acc_reg ^ data_in;
`endif
          if (cnt_reg == LAST_IDX) begin
`ifdef FRAME_CRC_EN
            state_next = CHECK;
`else
            swap_next  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            cnt_next = cnt_reg + ADDR_W'(1);
          end
        end
        BRIGHT: begin
          bright_next = data_in;
          state_next  = IDLE;
        end
`ifdef FRAME_CRC_EN
        CHECK: begin
          if (data_in == acc_reg) begin
            swap_next = 1'b1;
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  assign fb_we      = we_reg;
  assign fb_addr    = addr_reg;
  assign fb_data    = data_reg;
  assign brightness = bright_reg;
  assign swap       = swap_reg;
  assign frame_done = done_reg;
  assign err        = err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: randomized scoreboard bench for spi_frame_loader.
// The driver feeds a protocol-level model that queues expected output
// pulses; an independent monitor pops and compares them as they appear.
module tb_spi_frame_loader;
  localparam int AW = 2;
  localparam int FB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic          data_valid = 1'b0;
  logic          ce = 1'b1;
  logic          fb_we, swap, frame_done, err, busy;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data, brightness;

  spi_frame_loader #(.ADDR_W(AW), .FRAME_BYTES(FB)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .ce(ce), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .brightness(brightness), .swap(swap), .frame_done(frame_done),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic          sw;
    logic          done;
    logic          er;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  // protocol model: what the receiver is waiting for next
  int         mode = 0;        // 0 command, 1 pixel, 2 brightness, 3 checksum
  logic [7:0] pix[$];
  logic [7:0] bright_model = 8'hFF;
  bit         ce_on = 1'b0;    // model's view of the synchronised chip select
  logic [7:0] bright_exp_next = 8'hFF, bright_exp = 8'hFF;
  logic       busy_exp_next = 1'b0, busy_exp = 1'b0;
  bit         mon_en = 1'b0;

  function automatic ev_t mk(input logic we, sw, done, er,
                             input logic [AW-1:0] a, input logic [7:0] d);
    ev_t e;
    e.we = we; e.sw = sw; e.done = done; e.er = er; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic model_step(input logic [7:0] b);
    logic [7:0] x;
    case (mode)
      0: begin
        if (b == 8'hA0) begin
          mode = 1;
          pix.delete();
        end else if (b == 8'hB0) mode = 2;
        else if (b != 8'h00) exp_q.push_back(mk(0, 0, 0, 1, '0, '0));
      end
      1: begin
        pix.push_back(b);
        if (pix.size() == FB) begin
`ifdef FRAME_CRC_EN
          exp_q.push_back(mk(1, 0, 0, 0, AW'(pix.size() - 1), b));
          mode = 3;
`else
          exp_q.push_back(mk(1, 1, 1, 0, AW'(pix.size() - 1), b));
          mode = 0;
`endif
        end else begin
          exp_q.push_back(mk(1, 0, 0, 0, AW'(pix.size() - 1), b));
        end
      end
      2: begin
        bright_model = b;
        mode = 0;
      end
      default: begin
        x = 8'h00;
        foreach (pix[i]) x = x ^ pix[i];
        if (b == x) exp_q.push_back(mk(0, 1, 1, 0, '0, '0));
        else exp_q.push_back(mk(0, 0, 0, 1, '0, '0));
        mode = 0;
      end
    endcase
    bright_exp_next = bright_model;
    busy_exp_next   = (mode != 0);
  endtask

  task automatic cycle(input bit v, input logic [7:0] b);
    @(posedge clk); #1;
    data_valid = v;
    data_in    = b;
    if (v && ce_on) model_step(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00);
  endtask

  // Drop ce; the slot where the synchronised fall lands may carry a byte,
  // which must be discarded. Some strobes follow while deselected.
  task automatic abort(input bit with_byte, input logic [7:0] b, input int ign);
    @(posedge clk); #1;
    ce = 1'b0; data_valid = 1'b0;
    idle(1);
    @(posedge clk); #1;
    ce_on = 1'b0;
    data_valid = with_byte; data_in = b;
    if (mode != 0) exp_q.push_back(mk(0, 0, 0, 1, '0, '0));
    mode = 0;
    busy_exp_next = 1'b0;
    for (int i = 0; i < ign; i++) cycle(1, 8'($urandom));
    @(posedge clk); #1;
    ce = 1'b1; data_valid = 1'b0;
    idle(3);
    ce_on = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; data_valid = 1'b0;
    ce_on = 1'b0; mode = 0; bright_model = 8'hFF;
    bright_exp_next = 8'hFF; busy_exp_next = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(3);
    ce_on = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic send_frame(input bit good_crc, input int max_gap);
    cycle(1, 8'hA0);
    for (int i = 0; i < FB; i++) begin
      idle($urandom_range(max_gap, 0));
      cycle(1, 8'($urandom));
    end
`ifdef FRAME_CRC_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (pix[i]) x = x ^ pix[i];
      idle($urandom_range(max_gap, 0));
      cycle(1, good_crc ? x : ~x);
    end
`endif
  endtask

  // expected brightness/busy become visible one edge after the byte
  always @(posedge clk) begin
    bright_exp <= bright_exp_next;
    busy_exp   <= busy_exp_next;
  end

  // monitor: compare every output pulse against the scoreboard queue
  always @(negedge clk) begin
    if (mon_en) begin
      chk("brightness", 32'(brightness), 32'(bright_exp));
      chk("busy", 32'(busy), 32'(busy_exp));
      if (fb_we || swap || frame_done || err) begin
        ev_t a, e;
        a = mk(fb_we, swap, frame_done, err, fb_addr, fb_data);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=%h want=none", a);
        end else begin
          e = exp_q.pop_front();
          if (a.we !== e.we || a.sw !== e.sw || a.done !== e.done || a.er !== e.er ||
              (e.we && (a.addr !== e.addr || a.data !== e.data))) begin
            bad++;
            $display("FAIL output_event got=%h want=%h", a, e);
          end
        end
      end
    end
  end

  initial begin
    idle(3);
    reset = 1'b0;
    ce_on = 1'b0;
    mon_en = 1'b1;
    idle(5);
    ce_on = 1'b1;
    @(negedge clk);
    chk("rst_brightness", 32'(brightness), 32'hFF);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_swap", 32'(swap), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);

    // brightness command, back-to-back strobes
    cycle(1, 8'hB0); cycle(1, 8'h40); idle(2);
    chk("bright_40", 32'(brightness), 32'h40);

    // directed frame, back-to-back
    cycle(1, 8'hA0); cycle(1, 8'h11); cycle(1, 8'h22); cycle(1, 8'h33); cycle(1, 8'h44);
`ifdef FRAME_CRC_EN
    cycle(1, 8'h44);
    cycle(1, 8'hA0); cycle(1, 8'h11); cycle(1, 8'h22); cycle(1, 8'h33); cycle(1, 8'h44);
    cycle(1, 8'h00);
`endif
    idle(2);

    // abort mid-frame, then a fresh frame from address 0
    cycle(1, 8'hA0); cycle(1, 8'h11); cycle(1, 8'h22);
    abort(0, 8'h00, 2);
    send_frame(1, 0);
    idle(2);

    // illegal command, and a byte coincident with the abort
    cycle(1, 8'h5C); idle(1);
    cycle(1, 8'hA0); cycle(1, 8'h55);
    abort(1, 8'h66, 0);

    // reset mid-frame, brightness restored
    cycle(1, 8'hB0); cycle(1, 8'h12);
    cycle(1, 8'hA0); cycle(1, 8'h01); cycle(1, 8'h02);
    do_reset();
    chk("reset_addr", 32'(fb_addr), 0);
    chk("reset_bright", 32'(brightness), 32'hFF);
    send_frame(1, 1);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(7, 0))
        0, 1: send_frame($urandom_range(3, 0) != 0, $urandom_range(2, 0));
        2: begin cycle(1, 8'hB0); idle($urandom_range(1, 0)); cycle(1, 8'($urandom)); end
        3: cycle(1, ($urandom_range(1, 0) != 0) ? 8'h00 : 8'($urandom));
        4, 5: begin
          cycle(1, 8'hA0);
          for (int i = 0; i < int'($urandom_range(FB - 1, 0)); i++) cycle(1, 8'($urandom));
          abort($urandom_range(1, 0) != 0, 8'($urandom), $urandom_range(2, 0));
        end
        6: begin
          cycle(1, 8'hA0);
          for (int i = 0; i < int'($urandom_range(FB - 1, 0)); i++) cycle(1, 8'($urandom));
          if ($urandom_range(3, 0) == 0) do_reset();
        end
        default: idle($urandom_range(3, 0));
      endcase
    end
    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
